// File: rtl/io_pkg.sv
// Shared definitions for the IO access arbiter: device codes, FSM states,
// requester ids and the illegal-access rule.
package io_pkg;

    typedef enum logic [1:0] {
        DEV_LED  = 2'b00,
        DEV_SW   = 2'b01,
        DEV_TUBE = 2'b10,
        DEV_NONE = 2'b11
    } dev_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    // Switches are read-only; the unmapped window accepts nothing.
    function automatic logic isIllegal(input dev_e dev, input logic we);
        return (dev == DEV_NONE) || ((dev == DEV_SW) && we);
    endfunction

endpackage

// File: rtl/io_access_arbiter_if.sv
// Requester and peripheral-driver signals of the IO access arbiter.
// With IO_ARB_LOCK_EN defined the per-requester lock inputs are added.
interface io_access_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              iReqCpu, iReqDbg;
    logic              iWeCpu, iWeDbg;
    logic [3:0]        iAddrCpu, iAddrDbg;
    logic [DATA_W-1:0] iWdataCpu, iWdataDbg;
    logic              oAckCpu, oAckDbg;
    logic [DATA_W-1:0] oRdataCpu, oRdataDbg;
    logic              oErrCpu, oErrDbg;
`ifdef IO_ARB_LOCK_EN
    logic              iLockCpu, iLockDbg;
`endif
    logic              oDoLedWrite;
    logic [1:0]        oLightAddress;
    logic [DATA_W-1:0] oLightDataToWrite;
    logic              oDoSwitchRead;
    logic [1:0]        oSwitchAddress;
    logic [DATA_W-1:0] iSwitchDataRead;
    logic              oDoTubeWrite;
    logic [1:0]        oTubeAddress;
    logic [DATA_W-1:0] oTubeDataToWrite;

    modport slave (
`ifdef IO_ARB_LOCK_EN
        input  iLockCpu, iLockDbg,
`endif
        input  iReqCpu, iReqDbg, iWeCpu, iWeDbg, iAddrCpu, iAddrDbg,
        input  iWdataCpu, iWdataDbg, iSwitchDataRead,
        output oAckCpu, oAckDbg, oRdataCpu, oRdataDbg, oErrCpu, oErrDbg,
        output oDoLedWrite, oLightAddress, oLightDataToWrite,
        output oDoSwitchRead, oSwitchAddress,
        output oDoTubeWrite, oTubeAddress, oTubeDataToWrite
    );

    modport master (
`ifdef IO_ARB_LOCK_EN
        output iLockCpu, iLockDbg,
`endif
        output iReqCpu, iReqDbg, iWeCpu, iWeDbg, iAddrCpu, iAddrDbg,
        output iWdataCpu, iWdataDbg, iSwitchDataRead,
        input  oAckCpu, oAckDbg, oRdataCpu, oRdataDbg, oErrCpu, oErrDbg,
        input  oDoLedWrite, oLightAddress, oLightDataToWrite,
        input  oDoSwitchRead, oSwitchAddress,
        input  oDoTubeWrite, oTubeAddress, oTubeDataToWrite
    );

endinterface

// File: rtl/io_rr_picker.sv
// Two-way round-robin grant (combinational) with a registered tie pointer.
// IO_ARB_LOCK_EN lets the last-granted requester keep the grant via its lock.
module io_rr_picker
    import io_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic clk,
    input  logic rstN,
    input  logic reqCpu,
    input  logic reqDbg,
`ifdef IO_ARB_LOCK_EN
    input  logic lockCpu,
    input  logic lockDbg,
`endif
    input  logic update,
    input  logic updId,
    output logic anyReq,
    output logic gntId
);
    // prio is the id that wins the next tie; the last grantee is its inverse.
    logic prio;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)       prio <= RR_INIT;
        else if (update) prio <= ~updId;
    end

    always_comb begin
        anyReq = reqCpu | reqDbg;
        if (reqCpu && reqDbg) gntId = prio;
        else                  gntId = reqDbg ? REQ_DBG : REQ_CPU;
`ifdef IO_ARB_LOCK_EN
        if ((~prio == REQ_CPU) ? (lockCpu && reqCpu) : (lockDbg && reqDbg))
            gntId = ~prio;
`endif
    end

endmodule

// File: rtl/io_access_arbiter.sv
// Shares the LED, switch and tube drivers between the CPU MMIO port and the
// debug monitor. Optional IO_ARB_LOCK_EN adds lock-based grant retention.
module io_access_arbiter
    import io_pkg::*;
#(
    parameter int   DATA_W  = 16,
    parameter logic RR_INIT = 1'b0
) (
    input logic iCpuClock,
    input logic iCpuReset,
    io_access_arbiter_if.slave bus
);
    state_e            state, stateNext;
    logic              anyReq, pickId, pickWe, gntId, latWe, respPhase;
    logic              ledWr, swRd, tubeWr, illegal, ackCpu, ackDbg;
    dev_e              latDev;
    logic [3:0]        pickAddr;
    logic [DATA_W-1:0] pickWdata, respData;
    logic [DATA_W-1:0] ledShadow, tubeShadow, rdataCpuQ, rdataDbgQ;
    logic [1:0]        lightAddr, swAddr, tubeAddr;
    logic [DATA_W-1:0] lightData, tubeData;

    assign respPhase = (state == ST_RESP);

    io_rr_picker #(.RR_INIT(RR_INIT)) uPicker (
        .clk    (iCpuClock),
        .rstN   (iCpuReset),
        .reqCpu (bus.iReqCpu),
        .reqDbg (bus.iReqDbg),
`ifdef IO_ARB_LOCK_EN
        .lockCpu(bus.iLockCpu),
        .lockDbg(bus.iLockDbg),
`endif
        .update (respPhase),
        .updId  (gntId),
        .anyReq (anyReq),
        .gntId  (pickId)
    );

    assign pickWe    = (pickId == REQ_DBG) ? bus.iWeDbg    : bus.iWeCpu;
    assign pickAddr  = (pickId == REQ_DBG) ? bus.iAddrDbg  : bus.iAddrCpu;
    assign pickWdata = (pickId == REQ_DBG) ? bus.iWdataDbg : bus.iWdataCpu;

    always_ff @(posedge iCpuClock or negedge iCpuReset) begin
        if (!iCpuReset) state <= ST_IDLE;
        else            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        ledWr     = 1'b0;
        swRd      = 1'b0;
        tubeWr    = 1'b0;
        unique case (state)
            ST_IDLE:  if (anyReq) stateNext = ST_ISSUE;
            ST_ISSUE: begin
                stateNext = ST_RESP;
                ledWr     = (latDev == DEV_LED)  &&  latWe;
                swRd      = (latDev == DEV_SW)   && !latWe;
                tubeWr    = (latDev == DEV_TUBE) &&  latWe;
            end
            ST_RESP:  stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    assign illegal = isIllegal(latDev, latWe);

    always_comb begin
        respData = '0;
        if (!illegal) begin
            unique case (latDev)
                DEV_SW:   respData = bus.iSwitchDataRead;
                DEV_LED:  respData = ledShadow;
                DEV_TUBE: respData = tubeShadow;
                default:  respData = '0;
            endcase
        end
    end

    // Device address/data outputs are loaded at grant so they are valid
    // throughout ISSUE and hold until the next access to that device.
    always_ff @(posedge iCpuClock or negedge iCpuReset) begin
        if (!iCpuReset) begin
            gntId      <= REQ_CPU;
            latWe      <= 1'b0;
            latDev     <= DEV_LED;
            lightAddr  <= '0;
            lightData  <= '0;
            swAddr     <= '0;
            tubeAddr   <= '0;
            tubeData   <= '0;
            ledShadow  <= '0;
            tubeShadow <= '0;
            rdataCpuQ  <= '0;
            rdataDbgQ  <= '0;
        end else begin
            if (state == ST_IDLE && anyReq) begin
                gntId  <= pickId;
                latWe  <= pickWe;
                latDev <= dev_e'(pickAddr[3:2]);
                unique case (dev_e'(pickAddr[3:2]))
                    DEV_LED: begin
                        lightAddr <= pickAddr[1:0];
                        if (pickWe) lightData <= pickWdata;
                    end
                    DEV_SW:  swAddr <= pickAddr[1:0];
                    DEV_TUBE: begin
                        tubeAddr <= pickAddr[1:0];
                        if (pickWe) tubeData <= pickWdata;
                    end
                    default: ;
                endcase
            end
            if (ledWr)  ledShadow  <= lightData;
            if (tubeWr) tubeShadow <= tubeData;
            if (ackCpu) rdataCpuQ  <= respData;
            if (ackDbg) rdataDbgQ  <= respData;
        end
    end

    assign ackCpu = respPhase && (gntId == REQ_CPU);
    assign ackDbg = respPhase && (gntId == REQ_DBG);

    assign bus.oAckCpu           = ackCpu;
    assign bus.oAckDbg           = ackDbg;
    assign bus.oErrCpu           = ackCpu && illegal;
    assign bus.oErrDbg           = ackDbg && illegal;
    assign bus.oRdataCpu         = ackCpu ? respData : rdataCpuQ;
    assign bus.oRdataDbg         = ackDbg ? respData : rdataDbgQ;
    assign bus.oDoLedWrite       = ledWr;
    assign bus.oLightAddress     = lightAddr;
    assign bus.oLightDataToWrite = lightData;
    assign bus.oDoSwitchRead     = swRd;
    assign bus.oSwitchAddress    = swAddr;
    assign bus.oDoTubeWrite      = tubeWr;
    assign bus.oTubeAddress      = tubeAddr;
    assign bus.oTubeDataToWrite  = tubeData;

endmodule

// File: tb/tb_io_access_arbiter.sv
// Bench for io_access_arbiter: directed vector table, hand sequences for
// round-robin and reset mid-access, then random traffic against a model.
module tb_io_access_arbiter;

    logic clk = 1'b0;
    logic rstN;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    io_access_arbiter_if #(.DATA_W(16)) bus ();

    io_access_arbiter #(.DATA_W(16), .RR_INIT(1'b0)) dut (
        .iCpuClock(clk),
        .iCpuReset(rstN),
        .bus      (bus)
    );

    // Transaction-level reference: where the current access is in its
    // three-cycle life, what it is, and the visible device/readback state.
    int          mPhase;
    logic        mLast, mG, mWe;
    logic [1:0]  mDev;
    logic [15:0] mLedSh, mTubeSh;
    logic [15:0] mHeld [2];
    logic [1:0]  mLightAddr, mSwAddr, mTubeAddr;
    logic [15:0] mLightData, mTubeData;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        mPhase = 0; mLast = 1'b1; mG = 0; mWe = 0; mDev = 0;
        mLedSh = 0; mTubeSh = 0; mHeld[0] = 0; mHeld[1] = 0;
        mLightAddr = 0; mSwAddr = 0; mTubeAddr = 0; mLightData = 0; mTubeData = 0;
    endtask

    // Compare every output with the model for this cycle, then advance the
    // model using the inputs that the coming rising edge will sample.
    task automatic cycleCheck(input string tag);
        logic ill, w, we;
        logic [15:0] src, wd;
        logic [3:0] a;
        ill = (mDev == 2'd3) || (mDev == 2'd1 && mWe);
        src = ill ? 16'h0 : (mDev == 2'd1) ? bus.iSwitchDataRead :
              (mDev == 2'd0) ? mLedSh : mTubeSh;
        chk({tag, ".ledW"},  bus.oDoLedWrite,   32'(mPhase == 1 && mDev == 0 && mWe));
        chk({tag, ".swR"},   bus.oDoSwitchRead, 32'(mPhase == 1 && mDev == 1 && !mWe));
        chk({tag, ".tubeW"}, bus.oDoTubeWrite,  32'(mPhase == 1 && mDev == 2 && mWe));
        chk({tag, ".ackC"},  bus.oAckCpu, 32'(mPhase == 2 && mG == 0));
        chk({tag, ".ackD"},  bus.oAckDbg, 32'(mPhase == 2 && mG == 1));
        chk({tag, ".errC"},  bus.oErrCpu, 32'(mPhase == 2 && mG == 0 && ill));
        chk({tag, ".errD"},  bus.oErrDbg, 32'(mPhase == 2 && mG == 1 && ill));
        chk({tag, ".rdC"},   bus.oRdataCpu, (mPhase == 2 && mG == 0) ? src : mHeld[0]);
        chk({tag, ".rdD"},   bus.oRdataDbg, (mPhase == 2 && mG == 1) ? src : mHeld[1]);
        chk({tag, ".lAddr"}, bus.oLightAddress, mLightAddr);
        chk({tag, ".lData"}, bus.oLightDataToWrite, mLightData);
        chk({tag, ".sAddr"}, bus.oSwitchAddress, mSwAddr);
        chk({tag, ".tAddr"}, bus.oTubeAddress, mTubeAddr);
        chk({tag, ".tData"}, bus.oTubeDataToWrite, mTubeData);
        case (mPhase)
            0: if (bus.iReqCpu || bus.iReqDbg) begin
                w  = (bus.iReqCpu && bus.iReqDbg) ? ~mLast : (bus.iReqCpu ? 1'b0 : 1'b1);
                we = w ? bus.iWeDbg : bus.iWeCpu;
                a  = w ? bus.iAddrDbg : bus.iAddrCpu;
                wd = w ? bus.iWdataDbg : bus.iWdataCpu;
                mG = w; mWe = we; mDev = a[3:2];
                if (a[3:2] == 2'd0) begin mLightAddr = a[1:0]; if (we) mLightData = wd; end
                if (a[3:2] == 2'd1) mSwAddr = a[1:0];
                if (a[3:2] == 2'd2) begin mTubeAddr = a[1:0]; if (we) mTubeData = wd; end
                mPhase = 1;
            end
            1: begin
                if (mWe && mDev == 0) mLedSh  = mLightData;
                if (mWe && mDev == 2) mTubeSh = mTubeData;
                mPhase = 2;
            end
            default: begin
                mHeld[mG] = src;
                mLast = mG;
                mPhase = 0;
            end
        endcase
    endtask

    task automatic idleInputs();
        bus.iReqCpu = 0; bus.iReqDbg = 0; bus.iWeCpu = 0; bus.iWeDbg = 0;
        bus.iAddrCpu = 0; bus.iAddrDbg = 0; bus.iWdataCpu = 0; bus.iWdataDbg = 0;
        bus.iSwitchDataRead = 0;
`ifdef IO_ARB_LOCK_EN
        bus.iLockCpu = 0; bus.iLockDbg = 0;
`endif
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN = 0;
        idleInputs();
        #1;
        chk("rst.ledW", bus.oDoLedWrite, 0);
        chk("rst.swR", bus.oDoSwitchRead, 0);
        chk("rst.tubeW", bus.oDoTubeWrite, 0);
        chk("rst.acks", {bus.oAckCpu, bus.oAckDbg, bus.oErrCpu, bus.oErrDbg}, 0);
        chk("rst.rdata", {bus.oRdataCpu, bus.oRdataDbg}, 0);
        chk("rst.addr", {bus.oLightAddress, bus.oSwitchAddress, bus.oTubeAddress}, 0);
        chk("rst.data", {bus.oLightDataToWrite, bus.oTubeDataToWrite}, 0);
        modelReset();
        @(negedge clk);
        rstN = 1;
    endtask

    typedef struct {
        logic        who;
        logic        we;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        logic [2:0]  expStb;   // {led, switch, tube}
        logic [15:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t vecs [8];
    logic [15:0] prevR [2];
    int   ackCyc [$];
    logic ackId [$];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 4'b0001, 16'hA5A5, 16'h0000, 3'b100, 16'hA5A5, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 4'b0100, 16'h0000, 16'h00FF, 3'b010, 16'h00FF, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 4'b0110, 16'h5555, 16'h1111, 3'b000, 16'h0000, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 4'b1100, 16'h0000, 16'h2222, 3'b000, 16'h0000, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 4'b1000, 16'h1234, 16'h3333, 3'b001, 16'h1234, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 4'b1000, 16'h0000, 16'h4444, 3'b000, 16'h1234, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 4'b0011, 16'h0000, 16'h5555, 3'b000, 16'hA5A5, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 4'b0010, 16'h0F0F, 16'h6666, 3'b100, 16'h0F0F, 1'b0};
        prevR[0] = 0; prevR[1] = 0;

        rstN = 0;
        idleInputs();
        doReset();

        // Directed single-requester accesses.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idleInputs();
            if (vecs[i].who) begin
                bus.iReqDbg = 1; bus.iWeDbg = vecs[i].we;
                bus.iAddrDbg = vecs[i].addr; bus.iWdataDbg = vecs[i].wdata;
            end else begin
                bus.iReqCpu = 1; bus.iWeCpu = vecs[i].we;
                bus.iAddrCpu = vecs[i].addr; bus.iWdataCpu = vecs[i].wdata;
            end
            bus.iSwitchDataRead = vecs[i].sw;
            #1 cycleCheck($sformatf("v%0d.idle", i));
            @(negedge clk); #1;
            chk($sformatf("v%0d.strobes", i),
                {bus.oDoLedWrite, bus.oDoSwitchRead, bus.oDoTubeWrite}, vecs[i].expStb);
            if (vecs[i].expStb[2]) begin
                chk($sformatf("v%0d.lAddr", i), bus.oLightAddress, vecs[i].addr[1:0]);
                chk($sformatf("v%0d.lData", i), bus.oLightDataToWrite, vecs[i].wdata);
            end
            if (vecs[i].expStb[1]) chk($sformatf("v%0d.sAddr", i), bus.oSwitchAddress, vecs[i].addr[1:0]);
            if (vecs[i].expStb[0]) chk($sformatf("v%0d.tData", i), bus.oTubeDataToWrite, vecs[i].wdata);
            cycleCheck($sformatf("v%0d.issue", i));
            @(negedge clk); #1;
            chk($sformatf("v%0d.ack", i), vecs[i].who ? bus.oAckDbg : bus.oAckCpu, 1);
            chk($sformatf("v%0d.otherAck", i), vecs[i].who ? bus.oAckCpu : bus.oAckDbg, 0);
            chk($sformatf("v%0d.err", i), vecs[i].who ? bus.oErrDbg : bus.oErrCpu, vecs[i].expErr);
            chk($sformatf("v%0d.rdata", i), vecs[i].who ? bus.oRdataDbg : bus.oRdataCpu, vecs[i].expRdata);
            chk($sformatf("v%0d.otherRdata", i), vecs[i].who ? bus.oRdataCpu : bus.oRdataDbg,
                prevR[~vecs[i].who]);
            prevR[vecs[i].who] = vecs[i].expRdata;
            cycleCheck($sformatf("v%0d.resp", i));
        end

        // Both request continuously from reset: grants alternate CPU first.
        doReset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.iReqCpu = 1; bus.iReqDbg = 1;
            bus.iAddrCpu = 4'b0100; bus.iAddrDbg = 4'b0101;
            #1;
            if (bus.oAckCpu) begin ackCyc.push_back(c); ackId.push_back(1'b0); end
            if (bus.oAckDbg) begin ackCyc.push_back(c); ackId.push_back(1'b1); end
            cycleCheck($sformatf("rr%0d", c));
        end
        chk("rr.count", ackCyc.size(), 4);
        for (int k = 0; k < ackCyc.size() && k < 4; k++) begin
            chk($sformatf("rr.cyc%0d", k), ackCyc[k], 2 + 3 * k);
            chk($sformatf("rr.id%0d", k), ackId[k], k % 2);
        end

        // Reset during ISSUE abandons the access and restores the pointer.
        doReset();
        @(negedge clk);
        bus.iReqCpu = 1; bus.iWeCpu = 1; bus.iAddrCpu = 4'b0010; bus.iWdataCpu = 16'hBEEF;
        #1 cycleCheck("mid.idle");
        @(negedge clk);
        #1 cycleCheck("mid.issue");
        chk("mid.strobeUp", bus.oDoLedWrite, 1);
        #2 rstN = 0;
        bus.iReqCpu = 0;
        #1;
        chk("mid.strobeDrop", bus.oDoLedWrite, 0);
        chk("mid.ack", bus.oAckCpu, 0);
        chk("mid.lAddr", bus.oLightAddress, 0);
        modelReset();
        @(negedge clk);
        rstN = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 cycleCheck($sformatf("mid.quiet%0d", c));
            chk($sformatf("mid.noAck%0d", c), {bus.oAckCpu, bus.oAckDbg}, 0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.iReqCpu = 1; bus.iReqDbg = 1; bus.iWeCpu = 0; bus.iWeDbg = 0;
            bus.iAddrCpu = 4'b0000; bus.iAddrDbg = 4'b1000;
            #1 cycleCheck($sformatf("mid.tie%0d", c));
            if (c == 2) chk("mid.firstTieCpu", {bus.oAckCpu, bus.oAckDbg}, 2'b10);
        end

        // Random traffic; requests may drop early and change while busy.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            bus.iReqCpu = ($urandom_range(0, 3) != 0);
            bus.iReqDbg = ($urandom_range(0, 2) != 0);
            bus.iWeCpu = 1'($urandom); bus.iWeDbg = 1'($urandom);
            bus.iAddrCpu = 4'($urandom); bus.iAddrDbg = 4'($urandom);
            bus.iWdataCpu = 16'($urandom); bus.iWdataDbg = 16'($urandom);
            bus.iSwitchDataRead = 16'($urandom);
            #1 cycleCheck($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
